control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset; ports in order: clk in 1, clock, all state changes on rising edge; reset in 1, synchronous active-high.
REQ-002 The block SHALL have these inputs: opcode in 3, instruction class from decoder; op in 2, sub-operation from decoder.
REQ-003 The block SHALL drive these register-file controls: nsel out 3, one-hot register select (100=Rn, 010=Rd, 001=Rm, 000 otherwise); vsel out 4, one-hot writeback source (1000=mdata, 0100=sximm8, 0010=PC, 0001=C); write out 1, register-file write enable.
REQ-004 The block SHALL drive these datapath controls: loada, loadb, loadc, loads out 1 each, register/status loads; asel, bsel out 1 each, select zero for A / sximm5 for B.
REQ-005 The block SHALL drive these fetch and memory controls: load_ir, load_pc, reset_pc, addr_sel, load_addr out 1 each; mem_cmd out 2 (00 NONE, 01 READ, 10 WRITE).
REQ-006 The block SHALL drive halted out 1, high only in state HALT.

Function
REQ-007 The FSM SHALL be Moore-style: outputs depend on state plus opcode/op; opcode/op are IR-registered and stable from UPDATE_PC to the next IF2.
REQ-008 Any output not listed for a state SHALL be 0; nsel SHALL be 000 and vsel SHALL be 0000 unless listed.
REQ-009 States, per-state outputs and next state SHALL be:
  - RST: reset_pc, load_pc -> IF1
  - IF1: addr_sel, mem_cmd=READ -> IF2
  - IF2: addr_sel, mem_cmd=READ, load_ir -> UPDATE_PC
  - UPDATE_PC: load_pc -> DECODE
  - DECODE: no outputs; next state per REQ-010
  - GET_A: nsel=Rn, loada -> GET_B (ALU class) or ADDR_CALC (LDR/STR)
  - GET_B: nsel=Rm, loadb -> ALU
  - ALU: loadc; asel=1 when opcode 110; loads=1 and loadc=0 when CMP -> IF1 (CMP) else WRITE_REG
  - WRITE_REG: nsel=Rd, vsel=C, write -> IF1
  - MOV_IMM: nsel=Rn, vsel=sximm8, write -> IF1
  - ADDR_CALC: bsel, loadc -> LOAD_ADDR
  - LOAD_ADDR: load_addr -> MEM_RD (LDR) or STR_GETD (STR)
  - MEM_RD: mem_cmd=READ -> LDR_WB
  - LDR_WB: mem_cmd=READ, nsel=Rd, vsel=mdata, write -> IF1
  - STR_GETD: nsel=Rd, loadb -> STR_PASS
  - STR_PASS: asel, loadc -> STR_WR
  - STR_WR: mem_cmd=WRITE -> IF1
  - HALT: halted -> HALT
REQ-010 DECODE SHALL branch as follows:
  - 110/10 MOV imm -> MOV_IMM
  - 110/00 MOV reg -> GET_B
  - 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A
  - 101/11 MVN -> GET_B
  - 011/00 LDR, 100/00 STR -> GET_A
  - 111 -> HALT
  - any other encoding -> IF1 (treated as NOP; no write, no loads)
REQ-011 Instruction latency, counting IF1 as cycle 1 and ending in the final state, SHALL be: MOV imm 5; MOV reg/MVN 7; ADD/AND 8; CMP 7; LDR 9; STR 10.
REQ-012 write, load_ir, load_addr and mem_cmd=WRITE SHALL each be high for exactly one cycle per instruction that uses them.
REQ-013 HALT SHALL be left only by reset.

Reset
REQ-014 A clock edge with reset=1 SHALL force state RST from any state, including mid-instruction and HALT; no other state's side effects SHALL occur on that edge.
REQ-015 While in RST, outputs SHALL be reset_pc=1, load_pc=1, all others 0; the first IF1 SHALL follow the first edge with reset=0.

Structure
REQ-016 A shared package SHALL hold the state encoding constants, opcode/op constants, mem_cmd encodings (NONE/READ/WRITE), and nsel/vsel one-hot constants.
REQ-017 The state register SHALL be a separate parameterised sub-module, state_reg (width k, synchronous load, synchronous reset value parameter); next-state and output logic SHALL be combinational in control_fsm.

Verification
REQ-018 Reset/RST: hold reset 2 cycles, release -> RST outputs (reset_pc=1, load_pc=1) during reset, then IF1 with mem_cmd=01, addr_sel=1.
REQ-019 MOV imm and ADD:
  - opcode=110, op=10 -> write=1, nsel=100, vsel=0100 in cycle 5, then IF1.
  - opcode=101, op=00 -> loada at cycle 5, loadb at 6, loadc at 7, write with vsel=0001 at 8.
REQ-020 CMP: opcode=101, op=01 -> loads=1, loadc=0 in cycle 7; write never asserted; IF1 at cycle 8.
REQ-021 LDR/STR:
  - opcode=011 -> bsel+loadc at 6, load_addr at 7, mem_cmd=01 at 8-9, write with vsel=1000 at 9.
  - opcode=100 -> mem_cmd=10 only at cycle 10, write never asserted.
REQ-022 HALT and mid-operation reset:
  - opcode=111 -> halted=1 held for 20+ cycles with all other outputs 0.
  - reset asserted in ADDR_CALC -> RST next cycle, no load_addr pulse.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the instruction-sequencing controller: states, opcodes,
// memory commands and the one-hot register/writeback selects.
package control_fsm_pkg;

   localparam int STATE_W = 5;

   typedef enum logic [STATE_W-1:0] {
      S_RST       = 5'd0,
      S_IF1       = 5'd1,
      S_IF2       = 5'd2,
      S_UPDATE_PC = 5'd3,
      S_DECODE    = 5'd4,
      S_GET_A     = 5'd5,
      S_GET_B     = 5'd6,
      S_ALU       = 5'd7,
      S_WRITE_REG = 5'd8,
      S_MOV_IMM   = 5'd9,
      S_ADDR_CALC = 5'd10,
      S_LOAD_ADDR = 5'd11,
      S_MEM_RD    = 5'd12,
      S_LDR_WB    = 5'd13,
      S_STR_GETD  = 5'd14,
      S_STR_PASS  = 5'd15,
      S_STR_WR    = 5'd16,
      S_HALT      = 5'd17
   } state_t;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b100;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b001;

   localparam logic [3:0] VSEL_NONE   = 4'b0000;
   localparam logic [3:0] VSEL_MDATA  = 4'b1000;
   localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
   localparam logic [3:0] VSEL_PC     = 4'b0010;
   localparam logic [3:0] VSEL_C      = 4'b0001;

   function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] o);
      return (opc == OPC_ALU) && (o == OP_CMP);
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Decoder-to-controller inputs and all datapath/fetch/memory control strobes.
interface control_fsm_if;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] nsel;
   logic [3:0] vsel;
   logic       write;
   logic       loada;
   logic       loadb;
   logic       loadc;
   logic       loads;
   logic       asel;
   logic       bsel;
   logic       load_ir;
   logic       load_pc;
   logic       reset_pc;
   logic       addr_sel;
   logic       load_addr;
   logic [1:0] mem_cmd;
   logic       halted;

   modport master (
      input  opcode, op,
      output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
             load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
   );

   modport slave (
      output opcode, op,
      input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
             load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
   );

endinterface

// File: rtl/control_fsm_state_reg.sv
// Generic k-bit state register with synchronous load and synchronous reset value.
module state_reg #(
   parameter int           K         = 5,
   parameter logic [K-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [K-1:0] d,
   output logic [K-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= RESET_VAL;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/control_fsm.sv
// Moore controller sequencing fetch, decode and execute of one instruction at a time;
// the state flop lives in state_reg, everything here is combinational.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   control_fsm_if.master bus
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   state_t             state;
   state_t             next_state;

   assign state   = state_t'(state_q);
   assign state_d = next_state;

   state_reg #(
      .K         (STATE_W),
      .RESET_VAL (S_RST)
   ) u_state_reg (
      .clk   (clk),
      .reset (reset),
      .load  (1'b1),
      .d     (state_d),
      .q     (state_q)
   );

   // Every strobe defaults low so each state lists only what it asserts.
   always_comb begin
      next_state    = state;
      bus.nsel      = NSEL_NONE;
      bus.vsel      = VSEL_NONE;
      bus.write     = 1'b0;
      bus.loada     = 1'b0;
      bus.loadb     = 1'b0;
      bus.loadc     = 1'b0;
      bus.loads     = 1'b0;
      bus.asel      = 1'b0;
      bus.bsel      = 1'b0;
      bus.load_ir   = 1'b0;
      bus.load_pc   = 1'b0;
      bus.reset_pc  = 1'b0;
      bus.addr_sel  = 1'b0;
      bus.load_addr = 1'b0;
      bus.mem_cmd   = MEM_NONE;
      bus.halted    = 1'b0;

      case (state)
         S_RST: begin
            bus.reset_pc = 1'b1;
            bus.load_pc  = 1'b1;
            next_state   = S_IF1;
         end
         S_IF1: begin
            bus.addr_sel = 1'b1;
            bus.mem_cmd  = MEM_READ;
            next_state   = S_IF2;
         end
         S_IF2: begin
            bus.addr_sel = 1'b1;
            bus.mem_cmd  = MEM_READ;
            bus.load_ir  = 1'b1;
            next_state   = S_UPDATE_PC;
         end
         S_UPDATE_PC: begin
            bus.load_pc = 1'b1;
            next_state  = S_DECODE;
         end
         // Unrecognised encodings fall back to IF1 as a NOP.
         S_DECODE: begin
            next_state = S_IF1;
            case (bus.opcode)
               OPC_MOV: begin
                  if (bus.op == OP_MOV_IMM)
                     next_state = S_MOV_IMM;
                  else if (bus.op == OP_MOV_REG)
                     next_state = S_GET_B;
               end
               OPC_ALU:  next_state = (bus.op == OP_MVN) ? S_GET_B : S_GET_A;
               OPC_LDR:  if (bus.op == OP_MEM) next_state = S_GET_A;
               OPC_STR:  if (bus.op == OP_MEM) next_state = S_GET_A;
               OPC_HALT: next_state = S_HALT;
               default:  next_state = S_IF1;
            endcase
         end
         S_GET_A: begin
            bus.nsel   = NSEL_RN;
            bus.loada  = 1'b1;
            next_state = (bus.opcode == OPC_ALU) ? S_GET_B : S_ADDR_CALC;
         end
         S_GET_B: begin
            bus.nsel   = NSEL_RM;
            bus.loadb  = 1'b1;
            next_state = S_ALU;
         end
         // MOV reg passes B through by zeroing A; CMP only updates status.
         S_ALU: begin
            bus.asel = (bus.opcode == OPC_MOV);
            if (is_cmp(bus.opcode, bus.op)) begin
               bus.loads  = 1'b1;
               next_state = S_IF1;
            end else begin
               bus.loadc  = 1'b1;
               next_state = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            bus.nsel   = NSEL_RD;
            bus.vsel   = VSEL_C;
            bus.write  = 1'b1;
            next_state = S_IF1;
         end
         S_MOV_IMM: begin
            bus.nsel   = NSEL_RN;
            bus.vsel   = VSEL_SXIMM8;
            bus.write  = 1'b1;
            next_state = S_IF1;
         end
         S_ADDR_CALC: begin
            bus.bsel   = 1'b1;
            bus.loadc  = 1'b1;
            next_state = S_LOAD_ADDR;
         end
         S_LOAD_ADDR: begin
            bus.load_addr = 1'b1;
            next_state    = (bus.opcode == OPC_LDR) ? S_MEM_RD : S_STR_GETD;
         end
         S_MEM_RD: begin
            bus.mem_cmd = MEM_READ;
            next_state  = S_LDR_WB;
         end
         S_LDR_WB: begin
            bus.mem_cmd = MEM_READ;
            bus.nsel    = NSEL_RD;
            bus.vsel    = VSEL_MDATA;
            bus.write   = 1'b1;
            next_state  = S_IF1;
         end
         S_STR_GETD: begin
            bus.nsel   = NSEL_RD;
            bus.loadb  = 1'b1;
            next_state = S_STR_PASS;
         end
         S_STR_PASS: begin
            bus.asel   = 1'b1;
            bus.loadc  = 1'b1;
            next_state = S_STR_WR;
         end
         S_STR_WR: begin
            bus.mem_cmd = MEM_WRITE;
            next_state  = S_IF1;
         end
         S_HALT: begin
            bus.halted = 1'b1;
            next_state = S_HALT;
         end
         default: next_state = S_RST;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Directed cycle-by-cycle bench: each instruction's control word is compared
// against a hand-written expected sequence starting at IF1.
module tb_control_fsm;

   logic clk;
   logic reset;

   control_fsm_if bus ();

   control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount;
   int errorCount;

   // Control word layout {nsel, vsel, write, loada, loadb, loadc, loads, asel,
   // bsel, load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted}.
   localparam logic [21:0] B_HALTED    = 22'd1 << 0;
   localparam logic [21:0] M_READ      = 22'd1 << 1;
   localparam logic [21:0] M_WRITE     = 22'd2 << 1;
   localparam logic [21:0] B_LOAD_ADDR = 22'd1 << 3;
   localparam logic [21:0] B_ADDR_SEL  = 22'd1 << 4;
   localparam logic [21:0] B_RESET_PC  = 22'd1 << 5;
   localparam logic [21:0] B_LOAD_PC   = 22'd1 << 6;
   localparam logic [21:0] B_LOAD_IR   = 22'd1 << 7;
   localparam logic [21:0] B_BSEL      = 22'd1 << 8;
   localparam logic [21:0] B_ASEL      = 22'd1 << 9;
   localparam logic [21:0] B_LOADS     = 22'd1 << 10;
   localparam logic [21:0] B_LOADC     = 22'd1 << 11;
   localparam logic [21:0] B_LOADB     = 22'd1 << 12;
   localparam logic [21:0] B_LOADA     = 22'd1 << 13;
   localparam logic [21:0] B_WRITE     = 22'd1 << 14;
   localparam logic [21:0] V_C         = 22'd1 << 15;
   localparam logic [21:0] V_SXIMM8    = 22'd4 << 15;
   localparam logic [21:0] V_MDATA     = 22'd8 << 15;
   localparam logic [21:0] N_RM        = 22'd1 << 19;
   localparam logic [21:0] N_RD        = 22'd2 << 19;
   localparam logic [21:0] N_RN        = 22'd4 << 19;

   localparam logic [21:0] E_RST    = B_RESET_PC | B_LOAD_PC;
   localparam logic [21:0] E_IF1    = B_ADDR_SEL | M_READ;
   localparam logic [21:0] E_IF2    = B_ADDR_SEL | M_READ | B_LOAD_IR;
   localparam logic [21:0] E_UPD    = B_LOAD_PC;
   localparam logic [21:0] E_DEC    = 22'd0;
   localparam logic [21:0] E_GET_A  = N_RN | B_LOADA;
   localparam logic [21:0] E_GET_B  = N_RM | B_LOADB;
   localparam logic [21:0] E_WRREG  = N_RD | V_C | B_WRITE;

   logic [21:0] ctrlWord;
   assign ctrlWord = {bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb, bus.loadc,
                      bus.loads, bus.asel, bus.bsel, bus.load_ir, bus.load_pc,
                      bus.reset_pc, bus.addr_sel, bus.load_addr, bus.mem_cmd, bus.halted};

   logic [21:0] expSeq[$];

   task automatic checkOutput(input string tag, input logic [21:0] got, input logic [21:0] expected);
      checkCount++;
      if (got !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %06h expected %06h", tag, got, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Holds reset two edges (checking RST each time), loads the instruction
   // fields and releases reset; the next edge enters IF1 (cycle 1).
   task automatic applyStimulus(input string name, input logic [2:0] opc, input logic [1:0] o);
      @(negedge clk);
      reset      = 1'b1;
      bus.opcode = opc;
      bus.op     = o;
      stepCycle();
      checkOutput({name, " rst1"}, ctrlWord, E_RST);
      stepCycle();
      checkOutput({name, " rst2"}, ctrlWord, E_RST);
      reset = 1'b0;
   endtask

   task automatic runSequence(input string name);
      int cyc;
      cyc = 1;
      while (expSeq.size() > 0) begin
         stepCycle();
         checkOutput($sformatf("%s c%0d", name, cyc), ctrlWord, expSeq.pop_front());
         cyc++;
      end
   endtask

   task automatic pushFetch();
      expSeq.push_back(E_IF1);
      expSeq.push_back(E_IF2);
      expSeq.push_back(E_UPD);
      expSeq.push_back(E_DEC);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset      = 1'b1;
      bus.opcode = 3'b000;
      bus.op     = 2'b00;

      applyStimulus("movimm", 3'b110, 2'b10);
      pushFetch();
      expSeq.push_back(N_RN | V_SXIMM8 | B_WRITE);
      expSeq.push_back(E_IF1);
      expSeq.push_back(E_IF2);
      runSequence("movimm");

      applyStimulus("add", 3'b101, 2'b00);
      pushFetch();
      expSeq.push_back(E_GET_A);
      expSeq.push_back(E_GET_B);
      expSeq.push_back(B_LOADC);
      expSeq.push_back(E_WRREG);
      expSeq.push_back(E_IF1);
      runSequence("add");

      applyStimulus("cmp", 3'b101, 2'b01);
      pushFetch();
      expSeq.push_back(E_GET_A);
      expSeq.push_back(E_GET_B);
      expSeq.push_back(B_LOADS);
      expSeq.push_back(E_IF1);
      runSequence("cmp");

      applyStimulus("movreg", 3'b110, 2'b00);
      pushFetch();
      expSeq.push_back(E_GET_B);
      expSeq.push_back(B_LOADC | B_ASEL);
      expSeq.push_back(E_WRREG);
      expSeq.push_back(E_IF1);
      runSequence("movreg");

      applyStimulus("mvn", 3'b101, 2'b11);
      pushFetch();
      expSeq.push_back(E_GET_B);
      expSeq.push_back(B_LOADC);
      expSeq.push_back(E_WRREG);
      expSeq.push_back(E_IF1);
      runSequence("mvn");

      applyStimulus("ldr", 3'b011, 2'b00);
      pushFetch();
      expSeq.push_back(E_GET_A);
      expSeq.push_back(B_BSEL | B_LOADC);
      expSeq.push_back(B_LOAD_ADDR);
      expSeq.push_back(M_READ);
      expSeq.push_back(M_READ | N_RD | V_MDATA | B_WRITE);
      expSeq.push_back(E_IF1);
      runSequence("ldr");

      applyStimulus("str", 3'b100, 2'b00);
      pushFetch();
      expSeq.push_back(E_GET_A);
      expSeq.push_back(B_BSEL | B_LOADC);
      expSeq.push_back(B_LOAD_ADDR);
      expSeq.push_back(N_RD | B_LOADB);
      expSeq.push_back(B_ASEL | B_LOADC);
      expSeq.push_back(M_WRITE);
      expSeq.push_back(E_IF1);
      runSequence("str");

      applyStimulus("nop", 3'b000, 2'b00);
      pushFetch();
      expSeq.push_back(E_IF1);
      runSequence("nop");

      applyStimulus("ldrbadop", 3'b011, 2'b01);
      pushFetch();
      expSeq.push_back(E_IF1);
      runSequence("ldrbadop");

      applyStimulus("halt", 3'b111, 2'b00);
      pushFetch();
      for (int i = 0; i < 22; i++)
         expSeq.push_back(B_HALTED);
      runSequence("halt");

      // Reset is the only way out of HALT.
      reset = 1'b1;
      stepCycle();
      checkOutput("halt exit rst", ctrlWord, E_RST);
      reset = 1'b0;
      stepCycle();
      checkOutput("halt exit if1", ctrlWord, E_IF1);

      // Reset while in ADDR_CALC must suppress the LOAD_ADDR pulse.
      applyStimulus("midrst", 3'b011, 2'b00);
      pushFetch();
      expSeq.push_back(E_GET_A);
      expSeq.push_back(B_BSEL | B_LOADC);
      runSequence("midrst");
      reset = 1'b1;
      stepCycle();
      checkOutput("midrst c7", ctrlWord, E_RST);
      reset = 1'b0;
      stepCycle();
      checkOutput("midrst after", ctrlWord, E_IF1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
